room_manager: RTL and testbench

// - Upstream of the level background ROM: owns the current room index fed to its room input.
// - Samples the player position once per frame and detects when the player leaves the

---
 rtl/room_manager.sv | 191 +++++++++++++++++++
 tb/tb_room_manager.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/room_manager.sv
// Room index owner for the level ROM: watches the player at each frame tick, detects door
// exits and sequences fade-out, room swap with teleport, and fade-in.
module room_manager #(
   parameter logic [2:0]       START_ROOM  = 3'd0,
   parameter logic [3:0]       FADE_FRAMES = 4'd8,
   parameter logic [9:0]       EDGE_MARGIN = 10'd4,
   parameter logic [9:0]       SPRITE_SIZE = 10'd32,
   parameter logic [0:7][11:0] NEIGHBOURS  = {12'h3FF, 12'hE3F, {6{12'hFFF}}}
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   output logic [2:0] room,
   output logic [3:0] fade,
   output logic       transition_active,
   output logic       player_load,
   output logic [9:0] load_x,
   output logic [9:0] load_y
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      SWAP     = 2'd2,
      FADE_IN  = 2'd3
   } StateT;

   localparam logic [9:0] SOUTH_LIMIT = 10'd480 - SPRITE_SIZE - EDGE_MARGIN;
   localparam logic [9:0] EAST_LIMIT  = 10'd640 - SPRITE_SIZE - EDGE_MARGIN;
   localparam logic [9:0] NORTH_LAND  = SOUTH_LIMIT - 10'd1;
   localparam logic [9:0] WEST_LAND   = EAST_LIMIT - 10'd1;
   localparam logic [4:0] FADE_END    = {1'b0, FADE_FRAMES};

   // Fade level is floor(count*15/FADE_FRAMES) so the ramp ends exactly at 15.
   function automatic logic [3:0] fadeOf(input logic [4:0] c);
      logic [8:0] scaled;
      scaled = (9'(c) * 9'd15) / 9'(FADE_FRAMES);
      if (scaled > 9'd15)
         fadeOf = 4'd15;
      else
         fadeOf = scaled[3:0];
   endfunction

   StateT      r_state;
   logic [4:0] r_count;
   logic [3:0] r_fade;
   logic [2:0] r_room;
   logic [2:0] r_target;
   logic [9:0] r_loadX;
   logic [9:0] r_loadY;
   logic       r_skip;

   StateT      w_nextState;
   logic [4:0] w_nextCount;
   logic [3:0] w_nextFade;
   logic [2:0] w_nextRoom;
   logic [2:0] w_nextTarget;
   logic [9:0] w_nextLoadX;
   logic [9:0] w_nextLoadY;
   logic       w_nextSkip;

   logic [11:0] w_links;
   logic        w_hitN;
   logic        w_hitS;
   logic        w_hitW;
   logic        w_hitE;
   logic [2:0]  w_exitRoom;
   logic        w_exitValid;
   logic [9:0]  w_landX;
   logic [9:0]  w_landY;
   logic [4:0]  w_stepUp;
   logic [4:0]  w_stepDown;

   assign w_links     = NEIGHBOURS[r_room];
   assign w_hitN      = player_y < EDGE_MARGIN;
   assign w_hitS      = player_y > SOUTH_LIMIT;
   assign w_hitW      = player_x < EDGE_MARGIN;
   assign w_hitE      = player_x > EAST_LIMIT;
   assign w_exitValid = w_exitRoom != 3'b111;
   assign w_stepUp    = r_count + 5'd1;
   assign w_stepDown  = r_count - 5'd1;

   // Only the highest-priority edge is considered; a blocked edge masks lower ones.
   always_comb begin
      w_exitRoom = 3'b111;
      w_landX    = player_x;
      w_landY    = player_y;
      if (w_hitN) begin
         w_exitRoom = w_links[11:9];
         w_landY    = NORTH_LAND;
      end else if (w_hitS) begin
         w_exitRoom = w_links[8:6];
         w_landY    = EDGE_MARGIN;
      end else if (w_hitW) begin
         w_exitRoom = w_links[5:3];
         w_landX    = WEST_LAND;
      end else if (w_hitE) begin
         w_exitRoom = w_links[2:0];
         w_landX    = EDGE_MARGIN;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_nextCount  = r_count;
      w_nextFade   = r_fade;
      w_nextRoom   = r_room;
      w_nextTarget = r_target;
      w_nextLoadX  = r_loadX;
      w_nextLoadY  = r_loadY;
      w_nextSkip   = r_skip;
      case (r_state)
         IDLE: begin
            if (frame_tick) begin
               if (r_skip) begin
                  w_nextSkip = 1'b0;
               end else if (w_exitValid) begin
                  w_nextState  = FADE_OUT;
                  w_nextCount  = 5'd0;
                  w_nextTarget = w_exitRoom;
                  w_nextLoadX  = w_landX;
                  w_nextLoadY  = w_landY;
               end
            end
         end
         FADE_OUT: begin
            if (frame_tick) begin
               w_nextCount = w_stepUp;
               if (w_stepUp >= FADE_END) begin
                  w_nextFade  = 4'd15;
                  w_nextState = SWAP;
               end else begin
                  w_nextFade = fadeOf(w_stepUp);
               end
            end
         end
         SWAP: begin
            w_nextRoom  = r_target;
            w_nextCount = FADE_END;
            w_nextState = FADE_IN;
         end
         FADE_IN: begin
            if (frame_tick) begin
               w_nextCount = w_stepDown;
               if (w_stepDown == 5'd0) begin
                  w_nextFade  = 4'd0;
                  w_nextState = IDLE;
                  w_nextSkip  = 1'b1;
               end else begin
                  w_nextFade = fadeOf(w_stepDown);
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_count  <= 5'd0;
         r_fade   <= 4'd0;
         r_room   <= START_ROOM;
         r_target <= START_ROOM;
         r_loadX  <= 10'd0;
         r_loadY  <= 10'd0;
         r_skip   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_count  <= w_nextCount;
         r_fade   <= w_nextFade;
         r_room   <= w_nextRoom;
         r_target <= w_nextTarget;
         r_loadX  <= w_nextLoadX;
         r_loadY  <= w_nextLoadY;
         r_skip   <= w_nextSkip;
      end
   end

   assign room              = r_room;
   assign fade              = r_fade;
   assign transition_active = r_state != IDLE;
   assign player_load       = r_state == SWAP;
   assign load_x            = (r_state == SWAP) ? r_loadX : 10'd0;
   assign load_y            = (r_state == SWAP) ? r_loadY : 10'd0;

endmodule

// File: tb/tb_room_manager.sv
// Directed bench for room_manager: table of single-tick exit decisions plus hand-written
// full-transition, landing-skip and mid-fade reset sequences.
module tb_room_manager;

   logic       clock;
   logic       reset;
   logic       frameTick;
   logic [9:0] playerX;
   logic [9:0] playerY;
   logic [2:0] room;
   logic [3:0] fade;
   logic       transitionActive;
   logic       playerLoad;
   logic [9:0] loadX;
   logic [9:0] loadY;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic       expActive;
      logic [9:0] expX;
      logic [9:0] expY;
   } VecT;

   VecT vecs[10];
   int  fadeUp[8]   = '{1, 3, 5, 7, 9, 11, 13, 15};
   int  fadeDown[8] = '{13, 11, 9, 7, 5, 3, 1, 0};

   room_manager dut (
      .Clk              (clock),
      .Reset            (reset),
      .frame_tick       (frameTick),
      .player_x         (playerX),
      .player_y         (playerY),
      .room             (room),
      .fade             (fade),
      .transition_active(transitionActive),
      .player_load      (playerLoad),
      .load_x           (loadX),
      .load_y           (loadY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   // One frame tick; returns at the falling edge right after the consuming rising edge.
   task automatic applyStimulus();
      @(negedge clock);
      frameTick = 1'b1;
      @(negedge clock);
      frameTick = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clock);
      reset     = 1'b1;
      frameTick = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      frameTick = 1'b0;
      playerX   = 10'd300;
      playerY   = 10'd200;

      vecs[0] = '{10'd300, 10'd200, 1'b0, 10'd0,   10'd0};
      vecs[1] = '{10'd2,   10'd224, 1'b0, 10'd0,   10'd0};
      vecs[2] = '{10'd620, 10'd200, 1'b0, 10'd0,   10'd0};
      vecs[3] = '{10'd300, 10'd460, 1'b0, 10'd0,   10'd0};
      vecs[4] = '{10'd288, 10'd2,   1'b1, 10'd288, 10'd443};
      vecs[5] = '{10'd2,   10'd2,   1'b1, 10'd2,   10'd443};
      vecs[6] = '{10'd300, 10'd3,   1'b1, 10'd300, 10'd443};
      vecs[7] = '{10'd300, 10'd4,   1'b0, 10'd0,   10'd0};
      vecs[8] = '{10'd620, 10'd2,   1'b1, 10'd620, 10'd443};
      vecs[9] = '{10'd3,   10'd300, 1'b0, 10'd0,   10'd0};

      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset values.
      checkOutput("rstRoom", room, 0);
      checkOutput("rstFade", fade, 0);
      checkOutput("rstActive", transitionActive, 0);
      checkOutput("rstLoad", playerLoad, 0);
      checkOutput("rstLoadX", loadX, 0);
      checkOutput("rstLoadY", loadY, 0);

      // Exit decision table, each from a fresh reset in room 0.
      for (int i = 0; i < 10; i++) begin
         doReset();
         playerX = vecs[i].px;
         playerY = vecs[i].py;
         applyStimulus();
         checkOutput($sformatf("vec%0dActive", i), transitionActive, int'(vecs[i].expActive));
         if (vecs[i].expActive) begin
            for (int k = 0; k < 8; k++) applyStimulus();
            checkOutput($sformatf("vec%0dLoad", i), playerLoad, 1);
            checkOutput($sformatf("vec%0dLoadX", i), loadX, int'(vecs[i].expX));
            checkOutput($sformatf("vec%0dLoadY", i), loadY, int'(vecs[i].expY));
            checkOutput($sformatf("vec%0dRoomPre", i), room, 0);
            @(negedge clock);
            checkOutput($sformatf("vec%0dRoomPost", i), room, 1);
            checkOutput($sformatf("vec%0dLoadOff", i), playerLoad, 0);
         end else begin
            checkOutput($sformatf("vec%0dLoad", i), playerLoad, 0);
            checkOutput($sformatf("vec%0dRoom", i), room, 0);
         end
      end

      // Idle frames, then a blocked west exit held for 10 frames.
      doReset();
      playerX = 10'd300;
      playerY = 10'd200;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkOutput("idleActive", transitionActive, 0);
         checkOutput("idleLoad", playerLoad, 0);
         checkOutput("idleFade", fade, 0);
      end
      playerX = 10'd2;
      playerY = 10'd224;
      for (int k = 0; k < 10; k++) begin
         applyStimulus();
         checkOutput("westActive", transitionActive, 0);
         checkOutput("westRoom", room, 0);
      end

      // Full north transition with fade ramps.
      playerX = 10'd288;
      playerY = 10'd2;
      applyStimulus();
      checkOutput("trigActive", transitionActive, 1);
      checkOutput("trigFade", fade, 0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         checkOutput($sformatf("fadeOut%0d", k), fade, fadeUp[k]);
         if (k < 7) checkOutput($sformatf("fadeOutLoad%0d", k), playerLoad, 0);
      end
      checkOutput("swapLoad", playerLoad, 1);
      checkOutput("swapLoadX", loadX, 288);
      checkOutput("swapLoadY", loadY, 443);
      checkOutput("swapRoomHeld", room, 0);
      @(negedge clock);
      checkOutput("swapRoom", room, 1);
      checkOutput("swapFade", fade, 15);
      checkOutput("swapPulseEnd", playerLoad, 0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         checkOutput($sformatf("fadeIn%0d", k), fade, fadeDown[k]);
         checkOutput($sformatf("fadeInActive%0d", k), transitionActive, (k < 7) ? 1 : 0);
      end

      // Landing edge: first idle tick ignored, second returns south to room 0.
      playerY = 10'd446;
      applyStimulus();
      checkOutput("skipActive", transitionActive, 0);
      applyStimulus();
      checkOutput("southActive", transitionActive, 1);
      for (int k = 0; k < 8; k++) applyStimulus();
      checkOutput("southLoad", playerLoad, 1);
      checkOutput("southLoadX", loadX, 288);
      checkOutput("southLoadY", loadY, 4);
      @(negedge clock);
      checkOutput("southRoom", room, 0);

      // Reset on the 4th fade-out tick discards the transition.
      doReset();
      playerX = 10'd288;
      playerY = 10'd2;
      applyStimulus();
      for (int k = 0; k < 3; k++) applyStimulus();
      checkOutput("midFade", fade, 5);
      @(negedge clock);
      frameTick = 1'b1;
      reset     = 1'b1;
      @(negedge clock);
      frameTick = 1'b0;
      reset     = 1'b0;
      checkOutput("midRstRoom", room, 0);
      checkOutput("midRstFade", fade, 0);
      checkOutput("midRstActive", transitionActive, 0);
      playerX = 10'd300;
      playerY = 10'd200;
      applyStimulus();
      checkOutput("midRstIdle", transitionActive, 0);
      checkOutput("midRstIdleFade", fade, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
